// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-side memory controller between MEM stage and 8-bit RAM,
// with cache hit fast path and cache fill/write-through port.
//
// Ports:
//   clk, rst (async, active-low), rdy (global stall, 0 = freeze)
//   req_i/we_i/addr_i/byte_i/wdata_i : access request (latched on accept)
//   cache_hit_i/cache_data_i         : combinational cache lookup
//   busy_o/done_o/rdata_o            : status and load result
//   mem_din_i/mem_dout_o/mem_a_o/mem_wr_o : byte-wide RAM port
//   cache_we_o/cache_wbyte_o/cache_waddr_o/cache_wdata_o : cache update
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  byte_i,
  input  logic [31:0] wdata_i,
  input  logic        cache_hit_i,
  input  logic [31:0] cache_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  input  logic [7:0]  mem_din_i,
  output logic [7:0]  mem_dout_o,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o,
  output logic        cache_we_o,
  output logic [1:0]  cache_wbyte_o,
  output logic [31:0] cache_waddr_o,
  output logic [31:0] cache_wdata_o
);

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cach_q, cach_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        cwe_q, cwe_d;
  logic [1:0]  cwbyte_q, cwbyte_d;
  logic [31:0] cwaddr_q, cwaddr_d;
  logic [31:0] cwdata_q, cwdata_d;

  logic [1:0]  sz;
  logic [1:0]  lst;
  logic        cach;
  logic [1:0]  idx;
  logic [1:0]  nk;
  logic [31:0] rword;
  logic [7:0]  nbyte;

  // Size code 11 behaves as a single byte.
  always_comb begin
    sz  = (byte_i == 2'b11) ? 2'b00 : byte_i;
    lst = 2'd0;
    unique case (1'b1)
      (sz == 2'b10): lst = 2'd3;
      (sz == 2'b01): lst = 2'd1;
      default:       lst = 2'd0;
    endcase
    cach = (addr_i < IO_BASE);
  end

  // The byte on mem_din_i belongs to the address issued two edges ago,
  // so the slot being filled lags the counter by one.
  always_comb begin
    idx   = cnt_q[1:0] - 2'd1;
    rword = rbuf_q;
    unique case (idx)
      2'd0: rword[7:0]   = mem_din_i;
      2'd1: rword[15:8]  = mem_din_i;
      2'd2: rword[23:16] = mem_din_i;
      2'd3: rword[31:24] = mem_din_i;
      default: rword = rbuf_q;
    endcase
  end

  always_comb begin
    nk = cnt_q[1:0] + 2'd1;
    unique case (nk)
      2'd0: nbyte = wdata_q[7:0];
      2'd1: nbyte = wdata_q[15:8];
      2'd2: nbyte = wdata_q[23:16];
      2'd3: nbyte = wdata_q[31:24];
      default: nbyte = wdata_q[7:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cach_d     = cach_q;
    rbuf_d     = rbuf_q;
    rdata_d    = rdata_q;
    done_d     = done_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    cwe_d      = cwe_q;
    cwbyte_d   = cwbyte_q;
    cwaddr_d   = cwaddr_q;
    cwdata_d   = cwdata_q;
    // With rdy low everything holds, including pending pulses.
    if (rdy) begin
      done_d = 1'b0;
      cwe_d  = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_i) begin
            addr_d  = addr_i;
            size_d  = sz;
            last_d  = lst;
            wdata_d = wdata_i;
            cach_d  = cach;
            cnt_d   = 3'd0;
            rbuf_d  = 32'd0;
            if (we_i) begin
              state_d    = S_WRITE;
              mem_a_d    = addr_i;
              mem_wr_d   = 1'b1;
              mem_dout_d = wdata_i[7:0];
              if (cach) begin
                cwe_d    = 1'b1;
                cwbyte_d = sz;
                cwaddr_d = addr_i;
                cwdata_d = wdata_i;
              end
            end else if (cach && cache_hit_i) begin
              rdata_d = cache_data_i;
              done_d  = 1'b1;
            end else begin
              state_d  = S_READ;
              mem_a_d  = addr_i;
              mem_wr_d = 1'b0;
            end
          end
        end
        S_READ: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < {1'b0, last_q}) begin
            mem_a_d = addr_q + {29'd0, cnt_q} + 32'd1;
          end
          if (cnt_q != 3'd0) begin
            rbuf_d = rword;
          end
          if (cnt_q == ({1'b0, last_q} + 3'd1)) begin
            rdata_d = rword;
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (cach_q) begin
              cwe_d    = 1'b1;
              cwbyte_d = size_q;
              cwaddr_d = addr_q;
              cwdata_d = rword;
            end
          end
        end
        S_WRITE: begin
          if (cnt_q[1:0] == last_q) begin
            mem_wr_d = 1'b0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            mem_a_d    = addr_q + {29'd0, cnt_q} + 32'd1;
            mem_dout_d = nbyte;
          end
        end
        default: begin
          state_d  = S_IDLE;
          mem_wr_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      last_q     <= 2'd0;
      size_q     <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      cach_q     <= 1'b0;
      rbuf_q     <= 32'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      cwe_q      <= 1'b0;
      cwbyte_q   <= 2'd0;
      cwaddr_q   <= 32'd0;
      cwdata_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cach_q     <= cach_d;
      rbuf_q     <= rbuf_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      cwe_q      <= cwe_d;
      cwbyte_q   <= cwbyte_d;
      cwaddr_q   <= cwaddr_d;
      cwdata_q   <= cwdata_d;
    end
  end

  // Strobes are masked while frozen; the held flop re-fires once rdy returns.
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q & rdy;
  assign mem_wr_o      = mem_wr_q & rdy;
  assign cache_we_o    = cwe_q & rdy;
  assign rdata_o       = rdata_q;
  assign mem_a_o       = mem_a_q;
  assign mem_dout_o    = mem_dout_q;
  assign cache_wbyte_o = cwbyte_q;
  assign cache_waddr_o = cwaddr_q;
  assign cache_wdata_o = cwdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed testbench for dmem_ctrl with a 1-cycle
// latency byte RAM model; one task per scenario.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [1:0]  byte_i;
  logic [31:0] wdata_i;
  logic        cache_hit_i;
  logic [31:0] cache_data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic        cache_we_o;
  logic [1:0]  cache_wbyte_o;
  logic [31:0] cache_waddr_o;
  logic [31:0] cache_wdata_o;

  int vecs;
  int errs;

  dmem_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .req_i         (req_i),
    .we_i          (we_i),
    .addr_i        (addr_i),
    .byte_i        (byte_i),
    .wdata_i       (wdata_i),
    .cache_hit_i   (cache_hit_i),
    .cache_data_i  (cache_data_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .rdata_o       (rdata_o),
    .mem_din_i     (mem_din),
    .mem_dout_o    (mem_dout_o),
    .mem_a_o       (mem_a_o),
    .mem_wr_o      (mem_wr_o),
    .cache_we_o    (cache_we_o),
    .cache_wbyte_o (cache_wbyte_o),
    .cache_waddr_o (cache_waddr_o),
    .cache_wdata_o (cache_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    case (a)
      32'h100: rd_byte = 8'h11;
      32'h101: rd_byte = 8'h22;
      32'h102: rd_byte = 8'h33;
      32'h103: rd_byte = 8'h44;
      default: rd_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // RAM: read latency 1, output held while rdy is low.
  always @(posedge clk) begin
    if (rdy) mem_din <= rd_byte(mem_a_o);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_i = 1'b1; we_i = 1'b1;
    addr_i = 32'h100; byte_i = 2'b10; wdata_i = 32'h12345678;
    step(); step();
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL rst busy got %0h exp 0", busy_o); end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL rst done got %0h exp 0", done_o); end
    vecs++; if (mem_wr_o !== 1'b0) begin errs++; $display("FAIL rst mem_wr got %0h exp 0", mem_wr_o); end
    vecs++; if (cache_we_o !== 1'b0) begin errs++; $display("FAIL rst cache_we got %0h exp 0", cache_we_o); end
    vecs++; if (mem_a_o !== 32'h0) begin errs++; $display("FAIL rst mem_a got %0h exp 0", mem_a_o); end
    vecs++; if (rdata_o !== 32'h0) begin errs++; $display("FAIL rst rdata got %0h exp 0", rdata_o); end
    vecs++; if (mem_dout_o !== 8'h0) begin errs++; $display("FAIL rst mem_dout got %0h exp 0", mem_dout_o); end
    vecs++; if (cache_waddr_o !== 32'h0) begin errs++; $display("FAIL rst cache_waddr got %0h exp 0", cache_waddr_o); end
    req_i = 1'b0; we_i = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_lw_miss();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; byte_i = 2'b10;
    cache_hit_i = 1'b0;
    step();
    req_i = 1'b0; addr_i = 32'hDEAD0000;
    for (int c = 1; c <= 4; c++) begin
      vecs++; if (mem_a_o !== 32'h100 + c - 1) begin errs++; $display("FAIL lw_miss addr c%0d got %0h exp %0h", c, mem_a_o, 32'h100 + c - 1); end
      vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL lw_miss early done c%0d got %0h exp 0", c, done_o); end
      step();
    end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL lw_miss done c5 got %0h exp 0", done_o); end
    step();
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL lw_miss done c6 got %0h exp 1", done_o); end
    vecs++; if (rdata_o !== 32'h44332211) begin errs++; $display("FAIL lw_miss rdata got %0h exp 44332211", rdata_o); end
    vecs++; if (cache_we_o !== 1'b1) begin errs++; $display("FAIL lw_miss cache_we got %0h exp 1", cache_we_o); end
    vecs++; if (cache_wbyte_o !== 2'b10) begin errs++; $display("FAIL lw_miss wbyte got %0h exp 2", cache_wbyte_o); end
    vecs++; if (cache_waddr_o !== 32'h100) begin errs++; $display("FAIL lw_miss waddr got %0h exp 100", cache_waddr_o); end
    vecs++; if (cache_wdata_o !== 32'h44332211) begin errs++; $display("FAIL lw_miss wdata got %0h exp 44332211", cache_wdata_o); end
    vecs++; if (mem_wr_o !== 1'b0) begin errs++; $display("FAIL lw_miss mem_wr got %0h exp 0", mem_wr_o); end
    step();
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL lw_miss done pulse got %0h exp 0", done_o); end
    vecs++; if (cache_we_o !== 1'b0) begin errs++; $display("FAIL lw_miss cache_we pulse got %0h exp 0", cache_we_o); end
    vecs++; if (rdata_o !== 32'h44332211) begin errs++; $display("FAIL lw_miss rdata hold got %0h exp 44332211", rdata_o); end
  endtask

  task automatic test_lw_hit();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h200; byte_i = 2'b10;
    cache_hit_i = 1'b1; cache_data_i = 32'hDEADBEEF;
    step();
    req_i = 1'b0; cache_hit_i = 1'b0; cache_data_i = 32'h0;
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL lw_hit done got %0h exp 1", done_o); end
    vecs++; if (rdata_o !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_hit rdata got %0h exp deadbeef", rdata_o); end
    vecs++; if (mem_wr_o !== 1'b0) begin errs++; $display("FAIL lw_hit mem_wr got %0h exp 0", mem_wr_o); end
    vecs++; if (cache_we_o !== 1'b0) begin errs++; $display("FAIL lw_hit cache_we got %0h exp 0", cache_we_o); end
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL lw_hit busy got %0h exp 0", busy_o); end
    step();
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL lw_hit done pulse got %0h exp 0", done_o); end
  endtask

  task automatic test_sh();
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1FE; byte_i = 2'b01;
    wdata_i = 32'h0000ABCD;
    step();
    req_i = 1'b0; we_i = 1'b0; wdata_i = 32'hFFFFFFFF; addr_i = 32'h0;
    vecs++; if (mem_wr_o !== 1'b1) begin errs++; $display("FAIL sh c1 mem_wr got %0h exp 1", mem_wr_o); end
    vecs++; if (mem_a_o !== 32'h1FE) begin errs++; $display("FAIL sh c1 addr got %0h exp 1fe", mem_a_o); end
    vecs++; if (mem_dout_o !== 8'hCD) begin errs++; $display("FAIL sh c1 dout got %0h exp cd", mem_dout_o); end
    vecs++; if (cache_we_o !== 1'b1) begin errs++; $display("FAIL sh c1 cache_we got %0h exp 1", cache_we_o); end
    vecs++; if (cache_wbyte_o !== 2'b01) begin errs++; $display("FAIL sh c1 wbyte got %0h exp 1", cache_wbyte_o); end
    vecs++; if (cache_waddr_o !== 32'h1FE) begin errs++; $display("FAIL sh c1 waddr got %0h exp 1fe", cache_waddr_o); end
    vecs++; if (cache_wdata_o !== 32'h0000ABCD) begin errs++; $display("FAIL sh c1 wdata got %0h exp abcd", cache_wdata_o); end
    step();
    vecs++; if (mem_wr_o !== 1'b1) begin errs++; $display("FAIL sh c2 mem_wr got %0h exp 1", mem_wr_o); end
    vecs++; if (mem_a_o !== 32'h1FF) begin errs++; $display("FAIL sh c2 addr got %0h exp 1ff", mem_a_o); end
    vecs++; if (mem_dout_o !== 8'hAB) begin errs++; $display("FAIL sh c2 dout got %0h exp ab", mem_dout_o); end
    vecs++; if (cache_we_o !== 1'b0) begin errs++; $display("FAIL sh c2 cache_we got %0h exp 0", cache_we_o); end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL sh c2 done got %0h exp 0", done_o); end
    step();
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL sh c3 done got %0h exp 1", done_o); end
    vecs++; if (mem_wr_o !== 1'b0) begin errs++; $display("FAIL sh c3 mem_wr got %0h exp 0", mem_wr_o); end
    vecs++; if (rdata_o !== 32'hDEADBEEF) begin errs++; $display("FAIL sh rdata hold got %0h exp deadbeef", rdata_o); end
    step();
  endtask

  task automatic test_io();
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h30004; byte_i = 2'b00;
    wdata_i = 32'h00000041;
    step();
    req_i = 1'b0; we_i = 1'b0;
    vecs++; if (mem_wr_o !== 1'b1) begin errs++; $display("FAIL io_sb c1 mem_wr got %0h exp 1", mem_wr_o); end
    vecs++; if (mem_a_o !== 32'h30004) begin errs++; $display("FAIL io_sb c1 addr got %0h exp 30004", mem_a_o); end
    vecs++; if (mem_dout_o !== 8'h41) begin errs++; $display("FAIL io_sb c1 dout got %0h exp 41", mem_dout_o); end
    vecs++; if (cache_we_o !== 1'b0) begin errs++; $display("FAIL io_sb c1 cache_we got %0h exp 0", cache_we_o); end
    step();
    vecs++; if (mem_wr_o !== 1'b0) begin errs++; $display("FAIL io_sb c2 mem_wr got %0h exp 0", mem_wr_o); end
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL io_sb c2 done got %0h exp 1", done_o); end
    step();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h30000; byte_i = 2'b00;
    cache_hit_i = 1'b1; cache_data_i = 32'h11111111;
    step();
    req_i = 1'b0;
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL io_lb c1 done got %0h exp 0", done_o); end
    vecs++; if (mem_a_o !== 32'h30000) begin errs++; $display("FAIL io_lb c1 addr got %0h exp 30000", mem_a_o); end
    vecs++; if (busy_o !== 1'b1) begin errs++; $display("FAIL io_lb c1 busy got %0h exp 1", busy_o); end
    step();
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL io_lb c2 done got %0h exp 0", done_o); end
    step();
    cache_hit_i = 1'b0;
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL io_lb c3 done got %0h exp 1", done_o); end
    vecs++; if (rdata_o !== 32'h0000005A) begin errs++; $display("FAIL io_lb c3 rdata got %0h exp 5a", rdata_o); end
    vecs++; if (cache_we_o !== 1'b0) begin errs++; $display("FAIL io_lb c3 cache_we got %0h exp 0", cache_we_o); end
    step();
  endtask

  task automatic test_stall();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; byte_i = 2'b10;
    cache_hit_i = 1'b0;
    step();
    req_i = 1'b0;
    step(); step();
    rdy = 1'b0;
    step(); step();
    vecs++; if (mem_a_o !== 32'h102) begin errs++; $display("FAIL stall addr hold got %0h exp 102", mem_a_o); end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL stall c5 done got %0h exp 0", done_o); end
    rdy = 1'b1;
    step();
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL stall c6 done got %0h exp 0", done_o); end
    step();
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL stall c7 done got %0h exp 0", done_o); end
    step();
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL stall c8 done got %0h exp 1", done_o); end
    vecs++; if (rdata_o !== 32'h44332211) begin errs++; $display("FAIL stall rdata got %0h exp 44332211", rdata_o); end
    vecs++; if (cache_we_o !== 1'b1) begin errs++; $display("FAIL stall c8 cache_we got %0h exp 1", cache_we_o); end
    step();
    // Store whose write byte is suppressed by rdy=0 and re-issued.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; byte_i = 2'b00;
    wdata_i = 32'h00000099;
    step();
    req_i = 1'b0; we_i = 1'b0;
    rdy = 1'b0;
    #1;
    vecs++; if (mem_wr_o !== 1'b0) begin errs++; $display("FAIL stall_sb mem_wr forced got %0h exp 0", mem_wr_o); end
    vecs++; if (cache_we_o !== 1'b0) begin errs++; $display("FAIL stall_sb cache_we forced got %0h exp 0", cache_we_o); end
    step();
    vecs++; if (busy_o !== 1'b1) begin errs++; $display("FAIL stall_sb busy got %0h exp 1", busy_o); end
    rdy = 1'b1;
    #1;
    vecs++; if (mem_wr_o !== 1'b1) begin errs++; $display("FAIL stall_sb reissue mem_wr got %0h exp 1", mem_wr_o); end
    vecs++; if (mem_a_o !== 32'h40) begin errs++; $display("FAIL stall_sb addr got %0h exp 40", mem_a_o); end
    vecs++; if (mem_dout_o !== 8'h99) begin errs++; $display("FAIL stall_sb dout got %0h exp 99", mem_dout_o); end
    vecs++; if (cache_we_o !== 1'b1) begin errs++; $display("FAIL stall_sb late cache_we got %0h exp 1", cache_we_o); end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL stall_sb early done got %0h exp 0", done_o); end
    step();
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL stall_sb done got %0h exp 1", done_o); end
    vecs++; if (mem_wr_o !== 1'b0) begin errs++; $display("FAIL stall_sb end mem_wr got %0h exp 0", mem_wr_o); end
    step();
  endtask

  task automatic test_wrap();
    logic [31:0] ea [4];
    logic [7:0]  ed [4];
    ea[0] = 32'hFFFFFFFE; ea[1] = 32'hFFFFFFFF;
    ea[2] = 32'h00000000; ea[3] = 32'h00000001;
    ed[0] = 8'h21; ed[1] = 8'h43; ed[2] = 8'h65; ed[3] = 8'h87;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'hFFFFFFFE; byte_i = 2'b10;
    wdata_i = 32'h87654321;
    step();
    req_i = 1'b0; we_i = 1'b0; wdata_i = 32'h0;
    for (int k = 0; k < 4; k++) begin
      vecs++; if (mem_wr_o !== 1'b1) begin errs++; $display("FAIL wrap k%0d mem_wr got %0h exp 1", k, mem_wr_o); end
      vecs++; if (mem_a_o !== ea[k]) begin errs++; $display("FAIL wrap k%0d addr got %0h exp %0h", k, mem_a_o, ea[k]); end
      vecs++; if (mem_dout_o !== ed[k]) begin errs++; $display("FAIL wrap k%0d dout got %0h exp %0h", k, mem_dout_o, ed[k]); end
      vecs++; if (cache_we_o !== 1'b0) begin errs++; $display("FAIL wrap k%0d cache_we got %0h exp 0", k, cache_we_o); end
      step();
    end
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL wrap done got %0h exp 1", done_o); end
    vecs++; if (mem_wr_o !== 1'b0) begin errs++; $display("FAIL wrap end mem_wr got %0h exp 0", mem_wr_o); end
    step();
  endtask

  task automatic test_back_to_back();
    // Size code 11 acts as a single byte; req_i is held through busy.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; byte_i = 2'b11;
    wdata_i = 32'h00000077;
    step();
    vecs++; if (cache_we_o !== 1'b1) begin errs++; $display("FAIL b2b sb cache_we got %0h exp 1", cache_we_o); end
    vecs++; if (cache_wbyte_o !== 2'b00) begin errs++; $display("FAIL b2b sb wbyte got %0h exp 0", cache_wbyte_o); end
    we_i = 1'b0; addr_i = 32'h20; byte_i = 2'b10;
    cache_hit_i = 1'b1; cache_data_i = 32'h0000CAFE;
    step();
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL b2b sb done got %0h exp 1", done_o); end
    vecs++; if (rdata_o !== 32'h44332211) begin errs++; $display("FAIL b2b busy req taken rdata got %0h exp 44332211", rdata_o); end
    step();
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL b2b hit1 done got %0h exp 1", done_o); end
    vecs++; if (rdata_o !== 32'h0000CAFE) begin errs++; $display("FAIL b2b hit1 rdata got %0h exp cafe", rdata_o); end
    cache_data_i = 32'h0000BEEF;
    step();
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL b2b hit2 done got %0h exp 1", done_o); end
    vecs++; if (rdata_o !== 32'h0000BEEF) begin errs++; $display("FAIL b2b hit2 rdata got %0h exp beef", rdata_o); end
    req_i = 1'b0; cache_hit_i = 1'b0;
    step();
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL b2b idle done got %0h exp 0", done_o); end
    vecs++; if (rdata_o !== 32'h0000BEEF) begin errs++; $display("FAIL b2b rdata hold got %0h exp beef", rdata_o); end
  endtask

  task automatic test_async_reset();
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h300; byte_i = 2'b10;
    wdata_i = 32'hA5A5A5A5;
    step();
    req_i = 1'b0; we_i = 1'b0;
    vecs++; if (mem_wr_o !== 1'b1) begin errs++; $display("FAIL arst pre mem_wr got %0h exp 1", mem_wr_o); end
    #2 rst = 1'b0;
    #1;
    vecs++; if (mem_wr_o !== 1'b0) begin errs++; $display("FAIL arst mem_wr got %0h exp 0", mem_wr_o); end
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL arst busy got %0h exp 0", busy_o); end
    vecs++; if (cache_we_o !== 1'b0) begin errs++; $display("FAIL arst cache_we got %0h exp 0", cache_we_o); end
    step();
    rst = 1'b1;
    step();
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL arst after busy got %0h exp 0", busy_o); end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL arst after done got %0h exp 0", done_o); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1'b0;
    rdy = 1'b1;
    req_i = 1'b0;
    we_i = 1'b0;
    addr_i = 32'h0;
    byte_i = 2'b00;
    wdata_i = 32'h0;
    cache_hit_i = 1'b0;
    cache_data_i = 32'h0;
    test_reset();
    test_lw_miss();
    test_lw_hit();
    test_sh();
    test_io();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-side memory controller sitting between the MEM stage and the 8-bit unified RAM port, and acting as the fill/update agent for the byte-granular data cache. It serves 1/2/4-byte loads and stores, using a cache hit as a one-cycle fast path. Misses and I/O accesses are serialised into one RAM byte per cycle. Every cacheable store, and every cacheable load miss on completion, is pushed into the cache write port.

## Interface
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are uncached I/O: no hit fast path, no cache update.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- rdy  in  1  global ready; 0 freezes the block.
- req_i  in  1  access request, sampled only in IDLE.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address.
- byte_i  in  2  access size: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 is treated as 00.
- wdata_i  in  32  store data, little-endian, low bytes used.
- cache_hit_i  in  1  combinational hit from the data cache for addr_i/byte_i.
- cache_data_i  in  32  cache read data, zero-extended.
- busy_o  out  1  1 in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  load result, zero-extended; held until the next load completes.
- mem_din_i  in  8  RAM read byte.
- mem_dout_o  out  8  RAM write byte.
- mem_a_o  out  32  RAM byte address.
- mem_wr_o  out  1  RAM write strobe.
- cache_we_o  out  1  cache write pulse.
- cache_wbyte_o  out  2  size code, same encoding as byte_i.
- cache_waddr_o  out  32  base address of the cache update.
- cache_wdata_o  out  32  update data, little-endian.

## Operation
- States: IDLE, READ, WRITE.
- All outputs are registered. Reset value of every output is 0.
- n = 1, 2 or 4 bytes, from byte_i. At acceptance, addr, size, we and wdata are latched; the requester need not hold them.
- On acceptance, the cacheable flag is latched as (addr_i < IO_BASE).
- IDLE, load, cacheable, cache_hit_i=1:
  - rdata_o <= cache_data_i and done_o <= 1.
  - Stay in IDLE. No RAM or cache activity.
- IDLE, load, otherwise:
  - Go to READ with byte counter k=0.
  - mem_a_o <= addr_i and mem_wr_o <= 0.
- READ: mem_a_o steps addr+1 .. addr+n-1, one per cycle. Each returned byte j is written into rdata_o[8j+7:8j].
- READ, after byte n-1 is captured:
  - Upper rdata bytes are zeroed and done_o <= 1.
  - If cacheable, cache_we_o <= 1 with wbyte = size, waddr = addr, wdata = the assembled word.
  - Go to IDLE.
- IDLE, store:
  - Go to WRITE. mem_wr_o <= 1, mem_a_o <= addr, mem_dout_o <= wdata[7:0].
  - If cacheable, write through in the same cycle: cache_we_o <= 1, wbyte = size, waddr = addr, wdata = wdata_i.
- WRITE:
  - Byte k goes out at addr+k with wdata[8k+7:8k].
  - After byte n-1: mem_wr_o <= 0, done_o <= 1, go to IDLE.
- Address arithmetic is 32-bit modulo 2^32; addr+k wraps through 0xFFFFFFFF -> 0.
- done_o and cache_we_o are single-cycle pulses.
- A new req_i is accepted in the same cycle done_o is high, so back-to-back accesses have no bubble.
- req_i while busy is ignored.
- rdy=0:
  - No state, counter, rdata or address change, and no acceptance.
  - mem_wr_o forced to 0. A suppressed write byte is re-issued when rdy returns.
  - done_o and cache_we_o are held at 0; a pending pulse fires after rdy returns.
  - The RAM holds mem_din_i stable while rdy=0.
- rst low at any time: immediately IDLE, all outputs 0, mem_wr_o drops without waiting for a clock. The in-flight access is abandoned.

## Timing
- Cycle c means outputs as seen after the c-th rising edge following the edge that sampled req_i.
- RAM read latency is 1: the address driven in cycle c appears on mem_din_i in cycle c+1, and is sampled at edge c+2.
- Load hit: done_o in cycle 1.
- Load miss or I/O load:
  - mem_a_o = addr+c-1 in cycles 1..n.
  - done_o and rdata_o in cycle n+2, i.e. 3/4/6 cycles for n = 1/2/4.
  - cache_we_o in the same cycle as done_o.
- Store:
  - mem_wr_o=1 in cycles 1..n.
  - done_o in cycle n+1.
  - cache_we_o in cycle 1.
- Each rdy=0 cycle adds exactly one cycle to the remaining latency.

## Test plan
- Reset: hold rst=0, drive req_i=1 -> every output 0, busy_o=0; mem_wr_o drops asynchronously when rst falls mid-store.
- LW miss at 0x100, RAM bytes 11 22 33 44:
  - mem_a_o = 0x100..0x103 in cycles 1-4.
  - Cycle 6: done_o=1, rdata_o=0x44332211, cache_we_o=1, wbyte=10, waddr=0x100, wdata=0x44332211.
- LW hit at 0x200, cache_data_i=0xDEADBEEF -> cycle 1: done_o=1, rdata_o=0xDEADBEEF; mem_wr_o and cache_we_o stay 0.
- SH at 0x1FE with wdata 0x0000ABCD:
  - Cycle 1: mem_wr_o=1, mem_a_o=0x1FE, mem_dout_o=CD, cache_we_o=1, wbyte=01.
  - Cycle 2: mem_a_o=0x1FF, mem_dout_o=AB.
  - Cycle 3: done_o=1, mem_wr_o=0.
- I/O accesses:
  - SB 0x41 to 0x30004 -> one mem_wr_o cycle, no cache_we_o.
  - LB from 0x30000 with cache_hit_i=1 -> RAM read anyway, done_o in cycle 3, no cache_we_o.
- LW miss with rdy=0 for 2 cycles during cycle 3 -> done_o in cycle 8, same rdata_o.
- SW at 0xFFFFFFFE -> write addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
